// File: rtl/regfile_pkg.sv
// Shared constants and port-slicing helper for the scoreboarded register file.
package regfile_pkg;

   localparam int ZERO_IDX = 0;
   localparam int A0_IDX   = 10;

   // LSB position of port 'port' inside a bus of ports each 'width' bits wide
   function automatic int port_lsb(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: flush, then writeback clear, then issue set, all at one edge.
// Per-port ready lookup is combinational; a same-cycle writeback counts as ready when bypassing.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_RD        = 2,
   parameter int BYPASS        = 1
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_flush,
   input  logic                            i_wb_vld,
   input  logic [ADDRESS_WIDTH-1:0]        i_wb_addr,
   input  logic                            i_issue_vld,
   input  logic [ADDRESS_WIDTH-1:0]        i_issue_rd,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] i_rd_addr,
   output logic [NUM_RD-1:0]               o_rdy
);

   localparam int DEPTH = 2**ADDRESS_WIDTH;

   logic [DEPTH-1:0] r_busy;
   logic [DEPTH-1:0] w_busy_nxt;

   // Later assignments win: a new producer supersedes both flush and writeback
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_flush) begin
         w_busy_nxt = '0;
      end
      if (i_wb_vld) begin
         w_busy_nxt[i_wb_addr] = 1'b0;
      end
      if (i_issue_vld && (i_issue_rd != ADDRESS_WIDTH'(ZERO_IDX))) begin
         w_busy_nxt[i_issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_port
      logic [ADDRESS_WIDTH-1:0] w_addr;
      logic                     w_fwd;

      assign w_addr   = i_rd_addr[port_lsb(g, ADDRESS_WIDTH) +: ADDRESS_WIDTH];
      assign w_fwd    = (BYPASS != 0) && i_wb_vld && (i_wb_addr == w_addr);
      assign o_rdy[g] = (w_addr == ADDRESS_WIDTH'(ZERO_IDX)) || !r_busy[w_addr] || w_fwd;
   end

endmodule

// File: rtl/reg_file_sb.sv
// NUM_RD-read / 1-write register file with x0 tied to zero, optional write bypass and busy scoreboard.
// Reads are combinational, writes land at the clock edge; no backpressure, rdy flags RAW hazards.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_RD        = 2,
   parameter int BYPASS        = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_RD*ADDRESS_WIDTH-1:0] ad,
   output logic [NUM_RD*DATA_WIDTH-1:0]    rd,
   output logic [NUM_RD-1:0]               rdy,
   input  logic [ADDRESS_WIDTH-1:0]        ad3,
   input  logic                            we3,
   input  logic [DATA_WIDTH-1:0]           wd3,
   input  logic                            issue_valid,
   input  logic [ADDRESS_WIDTH-1:0]        issue_rd,
   input  logic                            flush,
   output logic [DATA_WIDTH-1:0]           a0
);

   localparam int DEPTH = 2**ADDRESS_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic                  w_wr_en;

   assign w_wr_en = we3 && (ad3 != ADDRESS_WIDTH'(ZERO_IDX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[ad3] <= wd3;
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDRESS_WIDTH-1:0] w_addr;
      logic [DATA_WIDTH-1:0]    w_dat;

      assign w_addr = ad[port_lsb(g, ADDRESS_WIDTH) +: ADDRESS_WIDTH];

      always_comb begin
         w_dat = r_regs[w_addr];
         if (w_addr == ADDRESS_WIDTH'(ZERO_IDX)) begin
            w_dat = '0;
         end else if ((BYPASS != 0) && w_wr_en && (ad3 == w_addr)) begin
            w_dat = wd3;
         end
      end

      assign rd[port_lsb(g, DATA_WIDTH) +: DATA_WIDTH] = w_dat;
   end

   // Observation tap comes from storage so it never shows a bypassed value
   assign a0 = r_regs[A0_IDX];

   reg_scoreboard #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .NUM_RD        (NUM_RD),
      .BYPASS        (BYPASS)
   ) u_scoreboard (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_flush     (flush),
      .i_wb_vld    (w_wr_en),
      .i_wb_addr   (ad3),
      .i_issue_vld (issue_valid),
      .i_issue_rd  (issue_rd),
      .i_rd_addr   (ad),
      .o_rdy       (rdy)
   );

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Provides NUM_RD combinational read ports, one synchronous write port, and x0 hardwired to zero.
- Optional write-to-read bypass.
- Integrated busy scoreboard so decode can detect RAW hazards against in-flight writebacks.
- Sits between decode (read/issue) and writeback (write), and exports x10 (a0) for test observation.

Parameters:
- ADDRESS_WIDTH, 5, register index width; must be >= 4 so that x10 exists; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_RD, 2, number of read ports; legal range 1..4.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = reads see storage only.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ad  in  NUM_RD*ADDRESS_WIDTH  packed read addresses; port i = bits [i*AW +: AW].
- rd  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rdy  out  NUM_RD  per-port operand-ready flag (no pending writer).
- ad3  in  ADDRESS_WIDTH  write address.
- we3  in  1  write enable.
- wd3  in  DATA_WIDTH  write data.
- issue_valid  in  1  an instruction writing issue_rd is issued this cycle.
- issue_rd  in  ADDRESS_WIDTH  destination of the issued instruction.
- flush  in  1  clear all busy bits (pipeline squash).
- a0  out  DATA_WIDTH  current architectural value of x10.

Behaviour:
- Reset (async assert, sync-safe deassert): all registers 0, all busy bits 0, a0 = 0; rd/rdy follow the combinational rules below (rdy all 1).
- Write: at posedge clk, if we3 && ad3 != 0, regs[ad3] <= wd3. Writes to x0 are ignored.
- Read (combinational, 0-cycle latency), per port i:
  - ad[i] == 0 -> rd[i] = 0.
  - Else if BYPASS && we3 && ad3 == ad[i] -> rd[i] = wd3.
  - Else rd[i] = regs[ad[i]].
- With BYPASS = 0, a read of the address being written returns the old value; the new value is visible the next cycle.
- Scoreboard, busy[0..2**AW-1], updated at posedge clk, applied in this order:
  1. flush clears all bits.
  2. we3 && ad3 != 0 clears busy[ad3].
  3. issue_valid && issue_rd != 0 sets busy[issue_rd].
- Priority follows from the order: issue set beats writeback clear and flush on the same address in the same cycle (a new producer supersedes the old one). busy[0] is never set.
- rdy[i] = (ad[i] == 0) || !busy[ad[i]] || (BYPASS && we3 && ad3 == ad[i]).
- a0 = regs[10], driven from storage, not bypassed; a write to x10 is reflected the cycle after the write edge.
- Multiple read ports may name the same address; each resolves independently with identical results.
- Write with we3 = 0: no state change regardless of ad3/wd3.
- Reset asserted mid-operation: storage and busy clear immediately; a write or issue coincident with the reset edge is discarded.

Decomposition:
- Package regfile_pkg:
  - constants ZERO_IDX = 0, A0_IDX = 10.
  - function for packed-port slicing.
- Sub-module reg_scoreboard (busy vector, flush/clear/set priority, per-port lookup) instantiated once; storage and read muxing stay in reg_file_sb.

Test Plan:
- Reset: assert rst mid-run after writing x5 = 0x1234 -> rd for ad = 5 reads 0, a0 = 0, all rdy = 1.
- x0 write: we3 = 1, ad3 = 0, wd3 = 0xDEADBEEF -> next cycle, reading ad = 0 gives 0 on every port.
- Bypass and write timing:
  - BYPASS = 1: same cycle we3 = 1, ad3 = 7, wd3 = 0xA5A5A5A5, ad[0] = 7 -> rd[0] = 0xA5A5A5A5 before the edge.
  - BYPASS = 0: same stimulus -> old value before the edge, 0xA5A5A5A5 after.
- a0 latency: write x10 = 0x00000042 at edge N -> a0 = 0x42 from edge N onward, and still the old value in the cycle the write is presented.
- Scoreboard lifecycle:
  - issue_rd = 3 -> next cycle rdy for ad = 3 is 0.
  - Writeback ad3 = 3 -> rdy = 1 in the writeback cycle (BYPASS = 1) and the following cycle.
- Simultaneous events:
  - issue_rd = 4 and writeback ad3 = 4 in the same cycle -> busy[4] = 1 after the edge.
  - flush together with issue_rd = 6 -> only busy[6] set.
  - NUM_RD = 4 with all ports ad = 9 -> identical rd/rdy on all ports.
